// File: rtl/fir_job_ctrl_mc.sv
// Job sequencer for a multi-channel FIR engine: loads the active coefficient
// taps, then issues one strided stream request per enabled channel per iteration.
module fir_job_ctrl_mc #(
    parameter int N_TAPS  = 16,
    parameter int COEFF_W = 32,
    parameter int N_CH    = 2,
    parameter int CNT_W   = 16,
    parameter int ADDR_W  = 32,
    parameter int N_CORES = 2,
    localparam int NT_W   = $clog2(N_TAPS) + 1,
    localparam int TIDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            cfg_nb_iter_i,
    input  logic [CNT_W-1:0]            cfg_len_i,
    input  logic [NT_W-1:0]             cfg_ntaps_i,
    input  logic                        cfg_simplemul_i,
    input  logic [N_CH-1:0]             cfg_ch_mask_i,
    input  logic [N_CH*ADDR_W-1:0]      cfg_base_i,
    input  logic [ADDR_W-1:0]           cfg_stride_i,
    input  logic [N_TAPS*COEFF_W-1:0]   cfg_coeff_i,
    output logic                        coeff_valid_o,
    input  logic                        coeff_ready_i,
    output logic [COEFF_W-1:0]          coeff_data_o,
    output logic [TIDX_W-1:0]           coeff_idx_o,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [ADDR_W-1:0]           req_addr_o,
    output logic [CNT_W:0]              req_len_o,
    output logic [CH_W-1:0]             req_ch_o,
    input  logic                        req_done_i,
    output logic                        busy_o,
    output logic [N_CORES-1:0]          done_evt_o,
    output logic [2:0]                  state_dbg_o
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never drops and payload never changes until that cycle.
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t                      state_q, state_d;
    logic [NT_W-1:0]             taps_q;
    logic [CNT_W:0]              iters_q, len_q, iter_q;
    logic [N_CH-1:0]             mask_q;
    logic [N_CH*ADDR_W-1:0]      base_q;
    logic [ADDR_W-1:0]           stride_q, offset_q;
    logic [N_TAPS*COEFF_W-1:0]   coeff_q;
    logic [TIDX_W-1:0]           tap_k;
    logic [CH_W-1:0]             ch_q, nxt_ch, first_ch;
    logic                        nxt_found, tap_last, iter_last;
    logic [NT_W:0]               ntaps_p1;
    logic [NT_W-1:0]             taps_d;

    assign ntaps_p1  = {1'b0, cfg_ntaps_i} + (NT_W+1)'(1);
    assign taps_d    = cfg_simplemul_i ? NT_W'(1)
                     : (ntaps_p1 > (NT_W+1)'(N_TAPS)) ? NT_W'(N_TAPS) : ntaps_p1[NT_W-1:0];
    assign tap_last  = (NT_W'(tap_k) == taps_q - NT_W'(1));
    assign iter_last = (iter_q == iters_q - (CNT_W+1)'(1));

    // Lowest enabled channel, and the next enabled channel above the current one.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        first_ch  = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (mask_q[j]) first_ch = CH_W'(j);
            if (mask_q[j] && (j > int'(ch_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = CH_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else if (clear_i) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_LOAD;
            S_LOAD:   if (coeff_ready_i && tap_last)
                          state_d = (mask_q == '0) ? S_FINISH : S_ISSUE;
            S_ISSUE:  if (req_ready_i) state_d = S_WAIT;
            S_WAIT:   if (req_done_i)
                          state_d = (!nxt_found && iter_last) ? S_FINISH : S_ISSUE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taps_q <= '0; iters_q <= '0; len_q <= '0; iter_q <= '0;
            mask_q <= '0; base_q <= '0; stride_q <= '0; offset_q <= '0;
            coeff_q <= '0; tap_k <= '0; ch_q <= '0;
        end else if (clear_i) begin
            taps_q <= '0; iters_q <= '0; len_q <= '0; iter_q <= '0;
            mask_q <= '0; base_q <= '0; stride_q <= '0; offset_q <= '0;
            coeff_q <= '0; tap_k <= '0; ch_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    taps_q   <= taps_d;
                    iters_q  <= {1'b0, cfg_nb_iter_i} + (CNT_W+1)'(1);
                    len_q    <= {1'b0, cfg_len_i} + (CNT_W+1)'(1);
                    mask_q   <= cfg_ch_mask_i;
                    base_q   <= cfg_base_i;
                    stride_q <= cfg_stride_i;
                    coeff_q  <= cfg_coeff_i;
                    tap_k    <= '0;
                end
                S_LOAD: if (coeff_ready_i) begin
                    tap_k <= tap_k + TIDX_W'(1);
                    if (tap_last) begin
                        iter_q   <= '0;
                        offset_q <= '0;
                        ch_q     <= first_ch;
                    end
                end
                // Running offset replaces i*stride; it wraps modulo 2^ADDR_W.
                S_WAIT: if (req_done_i) begin
                    if (nxt_found) begin
                        ch_q <= nxt_ch;
                    end else begin
                        ch_q     <= first_ch;
                        iter_q   <= iter_q + (CNT_W+1)'(1);
                        offset_q <= offset_q + stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        coeff_valid_o = 1'b0;
        coeff_data_o  = '0;
        coeff_idx_o   = '0;
        req_valid_o   = 1'b0;
        req_addr_o    = '0;
        req_len_o     = '0;
        req_ch_o      = '0;
        busy_o        = (state_q != S_IDLE);
        done_evt_o    = '0;
        state_dbg_o   = state_q;
        if (state_q == S_LOAD) begin
            coeff_valid_o = 1'b1;
            coeff_data_o  = coeff_q[tap_k*COEFF_W +: COEFF_W];
            coeff_idx_o   = tap_k;
        end
        if (state_q == S_ISSUE) begin
            req_valid_o = 1'b1;
            req_addr_o  = base_q[int'(ch_q)*ADDR_W +: ADDR_W] + offset_q;
            req_len_o   = len_q;
            req_ch_o    = ch_q;
        end
        if (state_q == S_FINISH) done_evt_o = '1;
    end

endmodule

// File: tb/tb_fir_job_ctrl_mc.sv
// Directed bench for fir_job_ctrl_mc: stimulus pushes expected coefficient
// transfers, requests and done events; a negedge monitor pops and compares.
module tb_fir_job_ctrl_mc;
    localparam int N_TAPS = 16, COEFF_W = 32, N_CH = 2, CNT_W = 16, ADDR_W = 32, N_CORES = 2;

    logic clk = 0, rst_ni = 0, clear_i = 0, start_i = 0;
    logic [CNT_W-1:0] cfg_nb_iter_i = '0, cfg_len_i = '0;
    logic [4:0] cfg_ntaps_i = '0;
    logic cfg_simplemul_i = 0;
    logic [N_CH-1:0] cfg_ch_mask_i = '0;
    logic [N_CH*ADDR_W-1:0] cfg_base_i = '0;
    logic [ADDR_W-1:0] cfg_stride_i = '0;
    logic [N_TAPS*COEFF_W-1:0] cfg_coeff_i = '0;
    logic coeff_valid_o, coeff_ready_i = 1;
    logic [COEFF_W-1:0] coeff_data_o;
    logic [3:0] coeff_idx_o;
    logic req_valid_o, req_ready_i = 1;
    logic [ADDR_W-1:0] req_addr_o;
    logic [CNT_W:0] req_len_o;
    logic [0:0] req_ch_o;
    logic req_done_i = 0, busy_o;
    logic [N_CORES-1:0] done_evt_o;
    logic [2:0] state_dbg_o;

    fir_job_ctrl_mc #(.N_TAPS(N_TAPS), .COEFF_W(COEFF_W), .N_CH(N_CH), .CNT_W(CNT_W),
                      .ADDR_W(ADDR_W), .N_CORES(N_CORES)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
        .cfg_nb_iter_i(cfg_nb_iter_i), .cfg_len_i(cfg_len_i), .cfg_ntaps_i(cfg_ntaps_i),
        .cfg_simplemul_i(cfg_simplemul_i), .cfg_ch_mask_i(cfg_ch_mask_i),
        .cfg_base_i(cfg_base_i), .cfg_stride_i(cfg_stride_i), .cfg_coeff_i(cfg_coeff_i),
        .coeff_valid_o(coeff_valid_o), .coeff_ready_i(coeff_ready_i),
        .coeff_data_o(coeff_data_o), .coeff_idx_o(coeff_idx_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_len_o(req_len_o), .req_ch_o(req_ch_o), .req_done_i(req_done_i),
        .busy_o(busy_o), .done_evt_o(done_evt_o), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [35:0] exp_coeff_q[$];
    logic [49:0] exp_req_q[$];
    int exp_done = 0;
    logic [COEFF_W-1:0] tap_val[N_TAPS];
    logic auto_done = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pops plus hold-stable and done-event checks.
    logic stall_c = 0, stall_r = 0, prev_trig = 0, prev_done = 0;
    logic [36:0] snap_c;
    logic [50:0] snap_r;
    always @(negedge clk) begin
        if (rst_ni) begin
            if (stall_c) check("coeff_hold", {32'd0, coeff_valid_o, coeff_idx_o, coeff_data_o}, {32'd0, snap_c});
            if (stall_r) check("req_hold", {13'd0, req_valid_o, req_ch_o, req_addr_o, req_len_o}, {13'd0, snap_r});
            if (coeff_valid_o && coeff_ready_i) begin
                if (exp_coeff_q.size() == 0) check("coeff_unexpected", 1, 0);
                else check("coeff", {coeff_idx_o, coeff_data_o}, exp_coeff_q.pop_front());
            end
            if (req_valid_o && req_ready_i) begin
                if (exp_req_q.size() == 0) check("req_unexpected", 1, 0);
                else check("req", {req_ch_o, req_addr_o, req_len_o}, exp_req_q.pop_front());
            end
            if (done_evt_o != '0) begin
                check("done_value", done_evt_o, 2'b11);
                check("done_expected", exp_done > 0, 1);
                check("done_latency", prev_trig, 1);
                check("done_one_cycle", prev_done, 0);
                check("done_busy", busy_o, 1);
                if (exp_done > 0) exp_done--;
            end
            if (prev_done) check("busy_after_done", busy_o, 0);
            stall_c   = coeff_valid_o && !coeff_ready_i;
            snap_c    = {coeff_valid_o, coeff_idx_o, coeff_data_o};
            stall_r   = req_valid_o && !req_ready_i;
            snap_r    = {req_valid_o, req_ch_o, req_addr_o, req_len_o};
            prev_trig = (coeff_valid_o && coeff_ready_i) || (req_done_i && busy_o);
            prev_done = (done_evt_o != '0);
        end
    end

    // Streamer model: completes each accepted request two cycles later.
    initial forever begin
        @(negedge clk);
        if (auto_done && req_valid_o && req_ready_i) begin
            @(posedge clk); @(posedge clk); #1 req_done_i = 1;
            @(posedge clk); #1 req_done_i = 0;
        end
    end

    task automatic set_cfg(input logic [15:0] nb_iter, input logic [15:0] len, input logic [4:0] ntaps,
                           input logic smul, input logic [1:0] mask, input logic [31:0] b0,
                           input logic [31:0] b1, input logic [31:0] stride);
        cfg_nb_iter_i = nb_iter; cfg_len_i = len; cfg_ntaps_i = ntaps; cfg_simplemul_i = smul;
        cfg_ch_mask_i = mask; cfg_base_i = {b1, b0}; cfg_stride_i = stride;
        for (int k = 0; k < N_TAPS; k++) cfg_coeff_i[k*COEFF_W +: COEFF_W] = tap_val[k];
    endtask

    task automatic push_coeffs(input int n);
        for (int k = 0; k < n; k++) exp_coeff_q.push_back({4'(k), tap_val[k]});
    endtask

    task automatic push_req(input logic ch, input logic [31:0] addr, input logic [16:0] len);
        exp_req_q.push_back({ch, addr, len});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1;
        @(posedge clk); #1 start_i = 0;
    endtask

    task automatic start_job();
        pulse_start();
        check("start_lat_valid", coeff_valid_o, 1);
        check("start_busy", busy_o, 1);
    endtask

    task automatic wait_idle(input string name);
        logic done_ok = 0;
        for (int n = 0; n < 3000 && !done_ok; n++) begin
            @(negedge clk);
            if (!busy_o) done_ok = 1;
        end
        check({name, "_timeout"}, done_ok, 1);
        repeat (4) @(negedge clk);
        check({name, "_coeff_left"}, exp_coeff_q.size(), 0);
        check({name, "_req_left"}, exp_req_q.size(), 0);
        check({name, "_done_left"}, exp_done, 0);
    endtask

    task automatic wait_req_valid(input string name);
        logic seen = 0;
        for (int n = 0; n < 500 && !seen; n++) begin
            @(negedge clk);
            if (req_valid_o) seen = 1;
        end
        check({name, "_req_timeout"}, seen, 1);
    endtask

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        for (int k = 0; k < N_TAPS; k++) tap_val[k] = 32'hA5A5_0000 + k * 32'h0101;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_coeff_valid", coeff_valid_o, 0);
        check("rst_req_valid", req_valid_o, 0);
        check("rst_done", done_evt_o, 0);
        check("rst_payload", {coeff_idx_o, coeff_data_o, req_addr_o, req_len_o, req_ch_o}, 0);
        check("rst_state", state_dbg_o, 0);
        @(posedge clk); #1 rst_ni = 1;

        // 1: three taps, one request
        set_cfg(0, 3, 2, 0, 2'b01, 32'h2000, 32'h9000, 32'h40);
        push_coeffs(3); push_req(0, 32'h2000, 17'd4); exp_done++;
        start_job(); wait_idle("t1");

        // 2: two channels, three iterations
        set_cfg(2, 7, 1, 0, 2'b11, 32'h1000, 32'h8000, 32'h40);
        push_coeffs(2);
        push_req(0, 32'h1000, 17'd8); push_req(1, 32'h8000, 17'd8);
        push_req(0, 32'h1040, 17'd8); push_req(1, 32'h8040, 17'd8);
        push_req(0, 32'h1080, 17'd8); push_req(1, 32'h8080, 17'd8);
        exp_done++;
        start_job(); wait_idle("t2");

        // 3: simplemul loads tap 0 only; channel 1 only
        set_cfg(0, 5, 15, 1, 2'b10, 32'h1000, 32'h8000, 32'h40);
        push_coeffs(1); push_req(1, 32'h8000, 17'd6); exp_done++;
        start_job(); wait_idle("t3");

        // 4: empty mask, done straight after coefficients
        set_cfg(3, 1, 4, 0, 2'b00, 32'h1000, 32'h8000, 32'h40);
        push_coeffs(5); exp_done++;
        start_job(); wait_idle("t4");

        // 5: backpressure, mid-job start and cfg changes
        set_cfg(1, 2, 1, 0, 2'b01, 32'h3000, 32'h7000, 32'h10);
        push_coeffs(2); push_req(0, 32'h3000, 17'd3); push_req(0, 32'h3010, 17'd3); exp_done++;
        coeff_ready_i = 0; req_ready_i = 0;
        start_job();
        repeat (5) @(posedge clk);
        #1 cfg_ch_mask_i = 2'b11; cfg_base_i = {32'hDEAD0000, 32'hBEEF0000};
        cfg_nb_iter_i = 9; cfg_len_i = 99; cfg_ntaps_i = 7; cfg_coeff_i = ~cfg_coeff_i;
        pulse_start();
        #1 coeff_ready_i = 1;
        wait_req_valid("t5");
        repeat (5) @(posedge clk);
        #1 req_ready_i = 1;
        wait_idle("t5");

        // 6: address wraps modulo 2^32
        set_cfg(1, 0, 0, 0, 2'b01, 32'hFFFF_FFC0, 32'h0, 32'h40);
        push_coeffs(1); push_req(0, 32'hFFFF_FFC0, 17'd1); push_req(0, 32'h0, 17'd1); exp_done++;
        start_job(); wait_idle("t6");

        // 7: clear while waiting for completion, then a normal job
        auto_done = 0;
        set_cfg(3, 0, 0, 0, 2'b01, 32'h5000, 32'h0, 32'h40);
        push_coeffs(1); push_req(0, 32'h5000, 17'd1);
        start_job();
        begin
            logic acc = 0;
            for (int n = 0; n < 100 && !acc; n++) begin
                @(negedge clk);
                if (req_valid_o && req_ready_i) acc = 1;
            end
            check("t7_accept_timeout", acc, 1);
        end
        @(posedge clk); #1 check("t7_in_wait", state_dbg_o, 3);
        clear_i = 1;
        @(posedge clk); #1 clear_i = 0;
        check("t7_busy", busy_o, 0);
        check("t7_state", state_dbg_o, 0);
        check("t7_outputs", {coeff_valid_o, req_valid_o, done_evt_o, coeff_data_o, req_addr_o}, 0);
        repeat (6) @(negedge clk);
        auto_done = 1;
        set_cfg(0, 3, 2, 0, 2'b01, 32'h2000, 32'h9000, 32'h40);
        push_coeffs(3); push_req(0, 32'h2000, 17'd4); exp_done++;
        start_job(); wait_idle("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
